// File: rtl/key_stepper.sv
// key_stepper: four debounced keys to one-cycle step pulses.
// Optional auto-repeat: define KEY_STEPPER_AUTOREPEAT_EN.
module key_stepper #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIRST_DELAY     = 12000000,
  parameter int unsigned REPEAT_PERIOD   = 4000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       game_state,
  input  logic       keyLeft,
  input  logic       keyRight,
  input  logic       keyUp,
  input  logic       keyDown,
  output logic       step_left,
  output logic       step_right,
  output logic       step_up,
  output logic       step_down,
  output logic [3:0] keys_held
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PDB  = 3'd1;
  localparam logic [2:0] S_HF   = 3'd2;
  localparam logic [2:0] S_HR   = 3'd3;
  localparam logic [2:0] S_RDB  = 3'd4;

  localparam logic [31:0] DB_LIM = DEBOUNCE_CYCLES;
  localparam logic [31:0] FD_LIM = FIRST_DELAY;
  localparam logic [31:0] RP_LIM = REPEAT_PERIOD;

`ifdef KEY_STEPPER_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [3:0] raw;
  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] fire_w;
  logic [3:0] held_w;
  logic [3:0] step_d;
  logic [3:0] step_q;

  assign raw = {keyDown, keyUp, keyRight, keyLeft};

  // two-flop synchronizer; inverted so 1 means pressed
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= ~raw;
      s2_q <= s1_q;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_key
    logic [2:0]  st_q, st_d;
    logic [31:0] dc_q, dc_d;
    logic [31:0] tc_q, tc_d;
    logic        rep_q, rep_d;
    logic [31:0] dc_nx, tc_nx, lim;
    logic        from_rep, tmo, fire;

    assign dc_nx = sat_inc(dc_q);
    assign tc_nx = sat_inc(tc_q);
    assign from_rep = (st_q == S_HR) ||
                      (st_q == S_RDB && rep_q);
    assign lim = from_rep ? RP_LIM : FD_LIM;
    assign tmo = AR_EN && (tc_nx >= lim);

    // per-key debounce / hold / repeat decision
    always_comb begin
      st_d  = st_q;
      dc_d  = dc_q;
      tc_d  = tc_q;
      rep_d = rep_q;
      fire  = 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (s2_q[k]) begin
            dc_d = 32'd1;
            if (32'd1 >= DB_LIM) begin
              st_d = S_HF;
              tc_d = '0;
              fire = 1'b1;
            end else begin
              st_d = S_PDB;
            end
          end
        end
        S_PDB: begin
          if (!s2_q[k]) begin
            st_d = S_IDLE;
          end else if (dc_nx >= DB_LIM) begin
            st_d = S_HF;
            tc_d = '0;
            fire = 1'b1;
          end else begin
            dc_d = dc_nx;
          end
        end
        S_HF, S_HR, S_RDB: begin
          if (s2_q[k]) begin
            if (tmo) begin
              st_d = S_HR;
              tc_d = '0;
              fire = 1'b1;
            end else begin
              st_d = from_rep ? S_HR : S_HF;
              tc_d = tc_nx;
            end
          end else if (st_q != S_RDB) begin
            rep_d = from_rep;
            dc_d  = 32'd1;
            st_d  = (32'd1 >= DB_LIM) ? S_IDLE : S_RDB;
          end else if (dc_nx >= DB_LIM) begin
            st_d = S_IDLE;
          end else begin
            dc_d = dc_nx;
          end
        end
        default: st_d = S_IDLE;
      endcase
      if (game_state) begin
        st_d = S_IDLE;
        fire = 1'b0;
      end
    end

    // per-key state and counters
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        st_q  <= S_IDLE;
        dc_q  <= '0;
        tc_q  <= '0;
        rep_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        dc_q  <= dc_d;
        tc_q  <= tc_d;
        rep_q <= rep_d;
      end
    end

    assign fire_w[k] = fire;
    assign held_w[k] = (st_q == S_HF) ||
                       (st_q == S_HR) ||
                       (st_q == S_RDB);
  end

  assign step_d = {fire_w[3] & ~fire_w[2],
                   fire_w[2] & ~fire_w[3],
                   fire_w[1] & ~fire_w[0],
                   fire_w[0] & ~fire_w[1]};

  // registered pulses after opposite-key cancel
  always_ff @(posedge CLOCK_50) begin
    if (reset) step_q <= '0;
    else       step_q <= step_d;
  end

  assign {step_down, step_up, step_right, step_left} =
    step_q & {4{~game_state}};
  assign keys_held = held_w & {4{~game_state}};

endmodule

// File: doc/key_stepper.md
KEY_STEPPER -- requirements
Module: key_stepper

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples needed to accept a press or release.
REQ-002 SHALL have parameter FIRST_DELAY, default 12000000: cycles from the first step pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 4000000: cycles between successive auto-repeat pulses.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port game_state, input, 1 bit: high holds the block idle (menu or game-over screen).
REQ-007 SHALL have ports keyLeft, keyRight, keyUp, keyDown, input, 1 bit each: raw asynchronous push-buttons, active-low.
REQ-008 SHALL have ports step_left, step_right, step_up, step_down, output, 1 bit each: one-cycle move pulses to the downstream cursor block, active-high.
REQ-009 SHALL have port keys_held, output, 4 bits {down,up,right,left}: debounced pressed level per key.

Function
REQ-010 SHALL pass each raw key through its own 2-flop synchronizer and invert it to form the pressed level before any other logic sees it.
REQ-011 SHALL run four identical, independent per-key FSMs with states IDLE, PRESS_DB, HELD_FIRST, HELD_REPEAT, RELEASE_DB.
REQ-012 IDLE -> PRESS_DB on a pressed sample; the debounce counter restarts at 1.
REQ-013 In PRESS_DB, any released sample SHALL return the FSM to IDLE.
REQ-014 When DEBOUNCE_CYCLES consecutive pressed samples are reached, PRESS_DB SHALL go to HELD_FIRST, set keys_held, and emit one step pulse in that same cycle.
REQ-015 As a consequence of REQ-010 and REQ-014, latency from a clean raw press to the step pulse SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-016 HELD_FIRST SHALL emit a pulse FIRST_DELAY cycles after the first pulse, then go to HELD_REPEAT.
REQ-017 HELD_REPEAT SHALL emit a pulse every REPEAT_PERIOD cycles.
REQ-018 In either HELD state, a released sample SHALL enter RELEASE_DB, freeze the delay/repeat counter and suppress pulses.
REQ-019 If a pressed sample arrives before release debounce completes, RELEASE_DB SHALL return to the HELD state it came from, with the counter unfrozen.
REQ-020 DEBOUNCE_CYCLES consecutive released samples SHALL take RELEASE_DB to IDLE and clear keys_held.
REQ-021 Opposite-key cancel: if step_left and step_right would both pulse in the same cycle, both SHALL be suppressed; step_up and step_down likewise. FSM states SHALL still advance.
REQ-022 Non-opposite pulses (e.g. left and up) SHALL pass in the same cycle.
REQ-023 All counters SHALL be 32-bit, SHALL saturate and never wrap, and SHALL compare with >=.
REQ-024 While game_state is high, all FSMs SHALL be forced to IDLE and all outputs driven to 0. After game_state falls, a key already held SHALL start a fresh press debounce.

Reset
REQ-025 While reset is high at a clock edge, all FSMs, synchronizers and counters SHALL clear; step_* SHALL be 0 and keys_held SHALL be 4'b0000 in the next cycle.
REQ-026 reset SHALL have priority over game_state.
REQ-027 A reset asserted mid-hold SHALL abort any pending pulse; a key still held after reset releases SHALL produce its first pulse only after a full new debounce (REQ-015).

Configuration
REQ-028 Macro KEY_STEPPER_AUTOREPEAT_EN SHALL select auto-repeat behaviour as follows:
- Defined: the HELD_REPEAT path and the timing of REQ-016/017 are built.
- Not defined: HELD_FIRST never times out; exactly one pulse per debounced press; FIRST_DELAY and REPEAT_PERIOD are unused.

Verification (DEBOUNCE_CYCLES=4, FIRST_DELAY=10, REPEAT_PERIOD=3)
REQ-029 Raw keyLeft low at cycle 0, held -> step_left high only at cycles 6, 16, 19, 22; keys_held[0]=1 from cycle 6.
REQ-030 keyRight glitches low for 3 cycles then high -> no step_right pulse, keys_held stays 0.
REQ-031 keyUp held, then a 2-cycle high glitch after its first pulse -> no extra pulse; the following repeat is delayed by exactly 2 cycles.
REQ-032 keyLeft and keyRight pressed in the same cycle -> no step_left or step_right pulse ever; keyLeft with keyUp -> simultaneous step_left and step_up at cycle 6.
REQ-033 reset pulsed 1 cycle at cycle 12 while keyDown held -> all outputs 0 at cycle 13; next step_down at reset release + 6.
REQ-034 game_state high while keyLeft held -> no pulses; game_state falls at cycle T -> first step_left at T+4; with KEY_STEPPER_AUTOREPEAT_EN undefined, a 50-cycle hold yields exactly one pulse.
